gat_feat_reader: RTL

- Downstream readout stage for the GAT accelerator.
- After inference completes, it sweeps the new-feature BRAM through the byte-addressed read port (feat_bram_addrb / feat_bram_dout) and packs the 8-bit output features four per 32-bit word.
- Packed words go to a valid/ready stream toward the DMA/PS side.
- It absorbs the fixed BRAM read latency and downstream backpressure using a credit-controlled byte FIFO.

---
 rtl/gat_pkg.sv | 20 ++
 rtl/gat_feat_reader_if.sv | 37 +++
 rtl/gat_sync_fifo.sv | 63 ++++++
 rtl/gat_feat_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared GAT accelerator types and constants used by the BRAM-facing blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gat_pkg;

    // Readout sequencing states shared by the GAT stream stages.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gat_state_t;

    // Output features packed into one 32-bit stream word.
    localparam int BYTES_PER_WORD = 4;

    // Entry index to BRAM byte address: every entry occupies one 32-bit slot.
    localparam int BYTE_ADDR_SHIFT = 2;

endpackage

// File: rtl/gat_feat_reader_if.sv
// Bundles the feature-BRAM read port and the packed output stream of the reader.
// Latency: n/a (wiring only).
// Backpressure: stream uses m_tvalid/m_tready; the BRAM port has none.
interface gat_feat_reader_if
    import gat_pkg::*;
#(
    parameter int ADDR_W = 18
);

    logic [ADDR_W-1:0]             feat_bram_addrb;
    logic [31:0]                   feat_bram_dout;
    logic [BYTES_PER_WORD*8-1:0]   m_tdata;
    logic                          m_tvalid;
    logic                          m_tready;
    logic                          m_tlast;

    // Reader side: drives the BRAM address and the stream.
    modport master (
        output feat_bram_addrb,
        input  feat_bram_dout,
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    // Environment side: BRAM model and stream consumer.
    modport slave (
        input  feat_bram_addrb,
        output feat_bram_dout,
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );

endinterface

// File: rtl/gat_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read data and an occupancy count.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored; callers gate with count/empty.
module gat_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

endmodule

// File: rtl/gat_feat_reader.sv
// Sweeps the new-feature BRAM after inference and packs 8-bit features four per 32-bit stream word.
// Latency: first word valid RD_LATENCY+6 cycles after start; steady state one byte per cycle.
// Backpressure: m_tready low holds the word and stops popping; reads stop once FIFO credits run out.
module gat_feat_reader
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           word_count,
    gat_feat_reader_if.master     bus
);

    localparam int IDX_W  = NEW_FEATURE_ADDR_W;
    localparam int ADDR_W = IDX_W + BYTE_ADDR_SHIFT;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = BYTES_PER_WORD * DATA_WIDTH;
    localparam int SLOT_W = $clog2(BYTES_PER_WORD) + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [CNT_W:0]    CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [SLOT_W-1:0] FULL_SLOTS = SLOT_W'(BYTES_PER_WORD);

    // ------------------------------------------------------------------
    // Control / FSM
    // ------------------------------------------------------------------
    gat_state_t state_q;
    gat_state_t state_d;
    logic       start_ok;

    // ------------------------------------------------------------------
    // Read issue and in-flight tracking
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      rd_idx_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [RD_LATENCY-1:0] infl_q;
    logic [CNT_W-1:0]      infl_cnt;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;

    // ------------------------------------------------------------------
    // Byte FIFO and packer
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_rd_dat;
    logic                  fifo_empty;
    logic                  hs;
    logic                  pop;
    logic [WORD_W-1:0]     pack_q;
    logic [WORD_W-1:0]     pack_d;
    logic [SLOT_W-1:0]     fill_q;
    logic [SLOT_W-1:0]     fill_d;
    logic                  tvalid_q;
    logic                  tvalid_d;
    logic                  tlast_q;
    logic                  tlast_d;
    logic [IDX_W-1:0]      pk_idx_q;
    logic [IDX_W-1:0]      pk_idx_d;

    // Only the low feature byte of each BRAM word carries data.
    logic unused_dout_hi;
    assign unused_dout_hi = ^bus.feat_bram_dout[31:DATA_WIDTH];

    assign start_ok = (state_q == IDLE) && start;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue && (rd_idx_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (hs && tlast_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Count reads still in the BRAM pipeline so they hold FIFO space in reserve.
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            infl_cnt = infl_cnt + CNT_W'(infl_q[i]);
        end
    end

    // A read is only issued when its byte is guaranteed a FIFO slot on arrival.
    assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, infl_cnt}) < CREDIT_LIM;
    assign issue     = (state_q == RUN) && credit_ok;
    assign push      = infl_q[RD_LATENCY-1];

    // Read index, held BRAM address and the in-flight valid shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q <= '0;
            addr_q   <= '0;
            infl_q   <= '0;
        end else begin
            infl_q <= RD_LATENCY'({infl_q, issue});
            if (start_ok) begin
                rd_idx_q <= '0;
            end else if (issue) begin
                addr_q   <= {rd_idx_q, {BYTE_ADDR_SHIFT{1'b0}}};
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.feat_bram_addrb = addr_q;

    gat_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_byte_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_dat (bus.feat_bram_dout[DATA_WIDTH-1:0]),
        .rd_en  (pop),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_cnt),
        .empty  (fifo_empty)
    );

    // A held word blocks popping; a handshake frees the packer in the same cycle.
    assign hs  = tvalid_q && bus.m_tready;
    assign pop = (!tvalid_q || hs) && !fifo_empty;

    // Packer next state: clear on handshake, then drop the popped byte into the next lane.
    always_comb begin
        pack_d   = pack_q;
        fill_d   = fill_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        pk_idx_d = pk_idx_q;
        if (hs) begin
            pack_d   = '0;
            fill_d   = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
        if (pop) begin
            pack_d[DATA_WIDTH*int'(fill_d[SLOT_W-2:0]) +: DATA_WIDTH] = fifo_rd_dat;
            fill_d   = fill_d + SLOT_W'(1);
            pk_idx_d = pk_idx_q + IDX_W'(1);
            if ((fill_d == FULL_SLOTS) || (pk_idx_q == LAST_IDX)) begin
                tvalid_d = 1'b1;
                tlast_d  = (pk_idx_q == LAST_IDX);
            end
        end
    end

    // Packer registers; a new readout starts from an empty word.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            pack_q   <= '0;
            fill_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            pk_idx_q <= '0;
        end else begin
            pack_q   <= pack_d;
            fill_q   <= fill_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            pk_idx_q <= pk_idx_d;
        end
    end

    assign bus.m_tdata  = pack_q;
    assign bus.m_tvalid = tvalid_q;
    assign bus.m_tlast  = tlast_q;

    // Handshaked-word counter; holds after DONE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            word_count <= '0;
        end else if (hs) begin
            word_count <= word_count + 32'd1;
        end
    end

endmodule
